// File: rtl/ddr5_pwrgd_pkg.sv
// ddr5_pwrgd_pkg: per-channel state type, timing defaults and channel-index width
// for the DDR5 PWRGD_FAIL receive monitor.
package ddr5_pwrgd_pkg;
    typedef enum logic [2:0] {ST_OFF, ST_ARM, ST_MON, ST_FILT, ST_FLT} ch_state_e;
    localparam int ARM_DLY_DEF = 20;
    localparam int DEB_CNT_DEF = 4;
    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ddr5_pwrgd_fail_monitor_if.sv
// ddr5_pwrgd_fail_monitor_if: BMC-side fault report and 4-phase clear handshake.
// master = BMC register file, slave = monitor.
interface ddr5_pwrgd_fail_monitor_if #(
    parameter int MC_SIZE = 4,
    parameter int CH_W    = ddr5_pwrgd_pkg::ch_w(MC_SIZE)
);
    logic               iClrFlt;
    logic               oFltAck;
    logic [MC_SIZE-1:0] oDimmFltLatched;
    logic               oFltPulse;
    logic               oFirstFltVld;
    logic [CH_W-1:0]    oFirstFltCh;
    logic [7:0]         oFltCnt;
    modport master (output iClrFlt,
                    input  oFltAck, oDimmFltLatched, oFltPulse, oFirstFltVld, oFirstFltCh, oFltCnt);
    modport slave  (input  iClrFlt,
                    output oFltAck, oDimmFltLatched, oFltPulse, oFirstFltVld, oFirstFltCh, oFltCnt);
endinterface

// File: rtl/ddr5_pwrgd_fail_ch_fsm.sv
// ddr5_pwrgd_fail_ch_fsm: one channel's PWRGD_FAIL synchronizer, arm/debounce FSM
// and counters; o_latch flags the cycle the channel is about to enter FLT.
module ddr5_pwrgd_fail_ch_fsm
    import ddr5_pwrgd_pkg::*;
#(
    parameter int ARM_DLY = ARM_DLY_DEF,
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic i_pin,
    input  logic i_pwrok,
    input  logic i_mask,
    input  logic i_clr,
    output logic o_flt,
    output logic o_latch
);
    localparam int AW = $clog2(ARM_DLY + 1);
    localparam int DW = $clog2(DEB_CNT + 1);
    ch_state_e       r_state;
    logic [1:0]      r_sync;
    logic [AW-1:0]   r_arm_cnt;
    logic [DW-1:0]   r_deb_cnt;
    logic            w_s;
    assign w_s     = r_sync[1];
    assign o_flt   = (r_state == ST_FLT);
    assign o_latch = (r_state == ST_FILT) && i_pwrok && !w_s && !i_mask &&
                     (r_deb_cnt == DW'(DEB_CNT - 1));
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_pin};
    end
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state   <= ST_OFF;
            r_arm_cnt <= '0;
            r_deb_cnt <= '0;
        end else begin
            case (r_state)
                ST_OFF: if (i_pwrok && w_s) begin
                    r_state   <= ST_ARM;
                    r_arm_cnt <= '0;
                end
                ST_ARM: begin
                    if (!i_pwrok) r_state <= ST_OFF;
                    else if (!w_s) r_arm_cnt <= '0;
                    else if (r_arm_cnt == AW'(ARM_DLY - 1)) r_state <= ST_MON;
                    else r_arm_cnt <= r_arm_cnt + 1'b1;
                end
                ST_MON: begin
                    if (!i_pwrok) r_state <= ST_OFF;
                    else if (!w_s && !i_mask) begin
                        r_state   <= ST_FILT;
                        r_deb_cnt <= '0;
                    end
                end
                ST_FILT: begin
                    if (!i_pwrok) r_state <= ST_OFF;
                    else if (w_s || i_mask) begin
                        r_state   <= ST_MON;
                        r_deb_cnt <= '0;
                    end else if (o_latch) r_state <= ST_FLT;
                    else r_deb_cnt <= r_deb_cnt + 1'b1;
                end
                // DRAMPWROK is ignored here so a fault survives power-down
                ST_FLT: if (i_clr && w_s) r_state <= ST_OFF;
                default: r_state <= ST_OFF;
            endcase
        end
    end
endmodule

// File: rtl/ddr5_pwrgd_fail_monitor.sv
// ddr5_pwrgd_fail_monitor: per-channel DIMM PWRGD_FAIL fault latching with clear handshake,
// first-fault capture and pulse; fault counter built only with DDR5_PWRGD_FLT_CNT_EN.
module ddr5_pwrgd_fail_monitor
    import ddr5_pwrgd_pkg::*;
#(
    parameter int MC_SIZE = 4,
    parameter int ARM_DLY = ARM_DLY_DEF,
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic [MC_SIZE-1:0]  iPWRGD_FAIL_CH_DIMM_CPU,
    input  logic [MC_SIZE-1:0]  iPWRGD_DRAMPWRGD_OK,
    input  logic [MC_SIZE-1:0]  iFpgaDrvLow,
    input  logic                iAdrEvent,
    ddr5_pwrgd_fail_monitor_if.slave bmc
);
    localparam int CH_W = ch_w(MC_SIZE);
    logic [MC_SIZE-1:0] w_flt;
    logic [MC_SIZE-1:0] w_latch;
    logic               w_clr;
    logic [CH_W-1:0]    w_first;
    logic               r_ack;
    logic               r_pulse;
    logic               r_vld;
    logic [CH_W-1:0]    r_first;
    assign w_clr = bmc.iClrFlt && !r_ack;
    for (genvar g = 0; g < MC_SIZE; g++) begin : g_ch
        ddr5_pwrgd_fail_ch_fsm #(.ARM_DLY(ARM_DLY), .DEB_CNT(DEB_CNT)) u_ch (
            .iClk    (iClk),
            .iRst_n  (iRst_n),
            .i_pin   (iPWRGD_FAIL_CH_DIMM_CPU[g]),
            .i_pwrok (iPWRGD_DRAMPWRGD_OK[g]),
            .i_mask  (iFpgaDrvLow[g] | iAdrEvent),
            .i_clr   (w_clr),
            .o_flt   (w_flt[g]),
            .o_latch (w_latch[g])
        );
    end
    always_comb begin
        w_first = '0;
        for (int k = MC_SIZE - 1; k >= 0; k--) if (w_latch[k]) w_first = CH_W'(k);
    end
    // a latch in the clear cycle wins over the clear and is recorded afresh
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_ack   <= 1'b0;
            r_pulse <= 1'b0;
            r_vld   <= 1'b0;
            r_first <= '0;
        end else begin
            r_ack   <= bmc.iClrFlt;
            r_pulse <= |w_latch;
            if ((|w_latch) && (w_clr || !r_vld)) begin
                r_vld   <= 1'b1;
                r_first <= w_first;
            end else if (w_clr) begin
                r_vld   <= 1'b0;
                r_first <= '0;
            end
        end
    end
`ifdef DDR5_PWRGD_FLT_CNT_EN
    logic [7:0] r_cnt;
    logic [7:0] w_add;
    logic [8:0] w_sum;
    always_comb begin
        w_add = '0;
        for (int k = 0; k < MC_SIZE; k++) w_add = w_add + 8'(w_latch[k]);
        w_sum = {1'b0, w_clr ? 8'd0 : r_cnt} + {1'b0, w_add};
    end
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_cnt <= '0;
        else         r_cnt <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
    assign bmc.oFltCnt = r_cnt;
`else
    assign bmc.oFltCnt = '0;
`endif
    assign bmc.oFltAck         = r_ack;
    assign bmc.oDimmFltLatched = w_flt;
    assign bmc.oFltPulse       = r_pulse;
    assign bmc.oFirstFltVld    = r_vld;
    assign bmc.oFirstFltCh     = r_first;
endmodule

// File: tb/tb_ddr5_pwrgd_fail_monitor.sv
// tb_ddr5_pwrgd_fail_monitor: directed scenarios plus randomized traffic checked against
// a run-length reference model of the PWRGD_FAIL rules.
module tb_ddr5_pwrgd_fail_monitor;
    localparam int MC  = 4;
    localparam int ARM = 20;
    localparam int DEB = 4;
`ifdef DDR5_PWRGD_FLT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic          iClk   = 1'b0;
    logic          iRst_n = 1'b0;
    logic [MC-1:0] pin    = '1;
    logic [MC-1:0] pwrok  = '0;
    logic [MC-1:0] drv    = '0;
    logic          adr    = 1'b0;
    int total = 0;
    int bad   = 0;
    ddr5_pwrgd_fail_monitor_if #(.MC_SIZE(MC)) bmc ();
    ddr5_pwrgd_fail_monitor #(.MC_SIZE(MC), .ARM_DLY(ARM), .DEB_CNT(DEB)) dut (
        .iClk                    (iClk),
        .iRst_n                  (iRst_n),
        .iPWRGD_FAIL_CH_DIMM_CPU (pin),
        .iPWRGD_DRAMPWRGD_OK     (pwrok),
        .iFpgaDrvLow             (drv),
        .iAdrEvent               (adr),
        .bmc                     (bmc)
    );
    always #5 iClk = ~iClk;
    // reference model: pin delayed two clocks, consecutive-cycle run lengths for arming and debounce
    bit s1 [MC];
    bit s2 [MC];
    bit armed [MC];
    bit lat [MC];
    int arm_run [MC];
    int lo_run [MC];
    bit m_ack, m_pulse, m_vld;
    int m_first, m_cnt;
    function automatic logic [MC-1:0] m_lat();
        logic [MC-1:0] v = '0;
        for (int i = 0; i < MC; i++) v[i] = lat[i];
        return v;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < MC; i++) begin
            s1[i] = 0; s2[i] = 0; armed[i] = 0; lat[i] = 0; arm_run[i] = 0; lo_run[i] = 0;
        end
        m_ack = 0; m_pulse = 0; m_vld = 0; m_first = 0; m_cnt = 0;
    endtask
    task automatic model_update();
        bit clr_eff = bmc.iClrFlt && !m_ack;
        int n = 0;
        int first = -1;
        for (int i = 0; i < MC; i++) begin
            bit s = s2[i];
            bit msk = drv[i] | adr;
            if (lat[i]) begin
                if (clr_eff && s) begin lat[i] = 0; armed[i] = 0; arm_run[i] = 0; end
            end else if (!pwrok[i]) begin
                armed[i] = 0; arm_run[i] = 0; lo_run[i] = 0;
            end else if (!armed[i]) begin
                if (s) begin
                    arm_run[i]++;
                    if (arm_run[i] == ARM + 1) begin armed[i] = 1; lo_run[i] = 0; end
                end else if (arm_run[i] > 0) arm_run[i] = 1;
            end else if (!s && !msk) begin
                lo_run[i]++;
                if (lo_run[i] == DEB + 1) begin
                    lat[i] = 1; armed[i] = 0; arm_run[i] = 0; lo_run[i] = 0; n++;
                    if (first < 0) first = i;
                end
            end else lo_run[i] = 0;
        end
        m_pulse = (n > 0);
        if (n > 0 && (clr_eff || !m_vld)) begin m_vld = 1; m_first = first; end
        else if (clr_eff) begin m_vld = 0; m_first = 0; end
        if (CNT_EN) m_cnt = ((clr_eff ? 0 : m_cnt) + n > 255) ? 255 : (clr_eff ? 0 : m_cnt) + n;
        m_ack = bmc.iClrFlt;
        for (int i = 0; i < MC; i++) begin s2[i] = s1[i]; s1[i] = pin[i]; end
    endtask
    task automatic tick();
        @(posedge iClk);
        model_update();
        #1;
    endtask
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask
    task automatic clear_flt();
        bmc.iClrFlt = 1'b1;
        ticks(2);
        bmc.iClrFlt = 1'b0;
        ticks(2);
    endtask
    task automatic settle();
        pin = '1; drv = '0; adr = 1'b0;
        ticks(3);
        clear_flt();
    endtask
    task automatic test_reset();
        iRst_n = 1'b0;
        bmc.iClrFlt = 1'b0;
        model_reset();
        repeat (3) @(posedge iClk);
        #1;
        total++;
        if ({bmc.oDimmFltLatched, bmc.oFltAck, bmc.oFltPulse, bmc.oFirstFltVld, bmc.oFirstFltCh, bmc.oFltCnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got latched=%b ack=%b pulse=%b vld=%b ch=%0d cnt=%0d want all 0",
                     bmc.oDimmFltLatched, bmc.oFltAck, bmc.oFltPulse, bmc.oFirstFltVld, bmc.oFirstFltCh, bmc.oFltCnt);
        end
        iRst_n = 1'b1;
    endtask
    task automatic test_single_fault();
        int pulses = 0;
        pwrok = 4'b0001; pin = '1;
        ticks(25);
        pin[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            pulses += int'(bmc.oFltPulse);
            if (k == 6) begin
                total++;
                if (bmc.oDimmFltLatched !== 4'b0000) begin bad++; $display("FAIL single_early: got %b want 0000", bmc.oDimmFltLatched); end
            end
            if (k == 7) begin
                total++;
                if (bmc.oDimmFltLatched !== 4'b0001) begin bad++; $display("FAIL single_latency: got %b want 0001", bmc.oDimmFltLatched); end
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL single_pulse: got %0d pulses want 1", pulses); end
        total++;
        if (bmc.oFirstFltVld !== 1'b1 || bmc.oFirstFltCh !== 2'd0) begin
            bad++; $display("FAIL single_first: got vld=%b ch=%0d want vld=1 ch=0", bmc.oFirstFltVld, bmc.oFirstFltCh);
        end
        total++;
        if (bmc.oFltCnt !== (CNT_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL single_cnt: got %0d want %0d", bmc.oFltCnt, CNT_EN ? 1 : 0); end
        settle();
        total++;
        if (bmc.oDimmFltLatched !== 4'b0000 || bmc.oFirstFltVld !== 1'b0 || bmc.oFltCnt !== 8'd0) begin
            bad++; $display("FAIL single_cleared: got latched=%b vld=%b cnt=%0d want 0", bmc.oDimmFltLatched, bmc.oFirstFltVld, bmc.oFltCnt);
        end
    endtask
    task automatic test_glitch();
        int len = $urandom_range(1, DEB);
        pwrok = '1;
        ticks(25);
        pin[2] = 1'b0;
        ticks(len);
        pin[2] = 1'b1;
        ticks(10);
        total++;
        if (bmc.oDimmFltLatched !== 4'b0000) begin bad++; $display("FAIL glitch_len%0d: got %b want 0000", len, bmc.oDimmFltLatched); end
        pin[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 6) begin
                total++;
                if (bmc.oDimmFltLatched[2] !== (k == 7)) begin
                    bad++; $display("FAIL glitch_rearmed_k%0d: got %b want %b", k, bmc.oDimmFltLatched[2], k == 7);
                end
            end
        end
        settle();
    endtask
    task automatic test_mask();
        int c = $urandom_range(0, MC - 1);
        drv[1] = 1'b1; pin[1] = 1'b0;
        ticks(20);
        pin[1] = 1'b1;
        ticks(3);
        drv[1] = 1'b0;
        ticks(8);
        total++;
        if (bmc.oDimmFltLatched !== 4'b0000) begin bad++; $display("FAIL mask_selfdrive: got %b want 0000", bmc.oDimmFltLatched); end
        adr = 1'b1; pin[c] = 1'b0;
        ticks(20);
        pin[c] = 1'b1;
        ticks(3);
        adr = 1'b0;
        ticks(8);
        total++;
        if (bmc.oDimmFltLatched !== 4'b0000) begin bad++; $display("FAIL mask_adr_ch%0d: got %b want 0000", c, bmc.oDimmFltLatched); end
    endtask
    task automatic test_simultaneous();
        int pulses = 0;
        pin[3] = 1'b0; pin[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); pulses += int'(bmc.oFltPulse); end
        total++;
        if (bmc.oDimmFltLatched !== 4'b1010) begin bad++; $display("FAIL simul_latched: got %b want 1010", bmc.oDimmFltLatched); end
        total++;
        if (bmc.oFirstFltVld !== 1'b1 || bmc.oFirstFltCh !== 2'd1) begin
            bad++; $display("FAIL simul_first: got vld=%b ch=%0d want vld=1 ch=1", bmc.oFirstFltVld, bmc.oFirstFltCh);
        end
        total++;
        if (bmc.oFltCnt !== (CNT_EN ? 8'd2 : 8'd0)) begin bad++; $display("FAIL simul_cnt: got %0d want %0d", bmc.oFltCnt, CNT_EN ? 2 : 0); end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL simul_pulse: got %0d pulses want 1", pulses); end
        settle();
    endtask
    task automatic test_clear();
        pwrok = '1;
        ticks(25);
        pin[0] = 1'b0;
        ticks(10);
        pin[0] = 1'b1; pwrok[0] = 1'b0;
        ticks(3);
        total++;
        if (bmc.oDimmFltLatched !== 4'b0001) begin bad++; $display("FAIL clear_survive_pwrdn: got %b want 0001", bmc.oDimmFltLatched); end
        bmc.iClrFlt = 1'b1;
        tick();
        total++;
        if (bmc.oDimmFltLatched !== 4'b0000 || bmc.oFltAck !== 1'b1 || bmc.oFirstFltVld !== 1'b0) begin
            bad++; $display("FAIL clear_high: got latched=%b ack=%b vld=%b want 0000/1/0", bmc.oDimmFltLatched, bmc.oFltAck, bmc.oFirstFltVld);
        end
        ticks(3);
        total++;
        if (bmc.oFltAck !== 1'b1) begin bad++; $display("FAIL clear_ack_hold: got %b want 1", bmc.oFltAck); end
        bmc.iClrFlt = 1'b0;
        tick();
        total++;
        if (bmc.oFltAck !== 1'b0) begin bad++; $display("FAIL clear_ack_drop: got %b want 0", bmc.oFltAck); end
        pwrok[0] = 1'b1;
        ticks(25);
        pin[0] = 1'b0;
        ticks(10);
        bmc.iClrFlt = 1'b1;
        tick();
        total++;
        if (bmc.oDimmFltLatched !== 4'b0001 || bmc.oFltAck !== 1'b1) begin
            bad++; $display("FAIL clear_low_hold: got latched=%b ack=%b want 0001/1", bmc.oDimmFltLatched, bmc.oFltAck);
        end
        bmc.iClrFlt = 1'b0;
        tick();
        total++;
        if (bmc.oFltAck !== 1'b0 || bmc.oDimmFltLatched !== 4'b0001) begin
            bad++; $display("FAIL clear_low_done: got latched=%b ack=%b want 0001/0", bmc.oDimmFltLatched, bmc.oFltAck);
        end
        settle();
        total++;
        if (bmc.oDimmFltLatched !== 4'b0000) begin bad++; $display("FAIL clear_after_release: got %b want 0000", bmc.oDimmFltLatched); end
    endtask
    task automatic test_random();
        pwrok = '1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < MC; i++) begin
                if (pin[i] ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 5) == 0)) pin[i] = ~pin[i];
                if (pwrok[i] ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 4) == 0)) pwrok[i] = ~pwrok[i];
                drv[i] = ($urandom_range(0, 9) == 0);
            end
            adr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 11) == 0) bmc.iClrFlt = ~bmc.iClrFlt;
            tick();
            total++;
            if (bmc.oDimmFltLatched !== m_lat()) begin bad++; $display("FAIL rand_latched@%0d: got %b want %b", cyc, bmc.oDimmFltLatched, m_lat()); end
            total++;
            if (bmc.oFltPulse !== m_pulse) begin bad++; $display("FAIL rand_pulse@%0d: got %b want %b", cyc, bmc.oFltPulse, m_pulse); end
            total++;
            if (bmc.oFirstFltVld !== m_vld || bmc.oFirstFltCh !== 2'(m_first)) begin
                bad++; $display("FAIL rand_first@%0d: got vld=%b ch=%0d want vld=%b ch=%0d", cyc, bmc.oFirstFltVld, bmc.oFirstFltCh, m_vld, m_first);
            end
            total++;
            if (bmc.oFltCnt !== 8'(m_cnt)) begin bad++; $display("FAIL rand_cnt@%0d: got %0d want %0d", cyc, bmc.oFltCnt, m_cnt); end
            total++;
            if (bmc.oFltAck !== m_ack) begin bad++; $display("FAIL rand_ack@%0d: got %b want %b", cyc, bmc.oFltAck, m_ack); end
        end
        bmc.iClrFlt = 1'b0; pwrok = '1;
        settle();
    endtask
    task automatic test_async_reset();
        ticks(25);
        pin[0] = 1'b0;
        ticks(10);
        pin[2] = 1'b0;
        ticks(4);
        #2 iRst_n = 1'b0;
        #1;
        total++;
        if ({bmc.oDimmFltLatched, bmc.oFltAck, bmc.oFltPulse, bmc.oFirstFltVld, bmc.oFirstFltCh, bmc.oFltCnt} !== '0) begin
            bad++; $display("FAIL async_rst_filt: got latched=%b vld=%b cnt=%0d want 0", bmc.oDimmFltLatched, bmc.oFirstFltVld, bmc.oFltCnt);
        end
        pin = '1;
        #1 iRst_n = 1'b1;
        model_reset();
        ticks(25);
        pin[1] = 1'b0;
        ticks(10);
        bmc.iClrFlt = 1'b1;
        tick();
        #2 iRst_n = 1'b0;
        #1;
        total++;
        if ({bmc.oDimmFltLatched, bmc.oFltAck, bmc.oFltPulse, bmc.oFirstFltVld, bmc.oFirstFltCh, bmc.oFltCnt} !== '0) begin
            bad++; $display("FAIL async_rst_hs: got latched=%b ack=%b vld=%b want 0", bmc.oDimmFltLatched, bmc.oFltAck, bmc.oFirstFltVld);
        end
        bmc.iClrFlt = 1'b0; pin = '1;
        #1 iRst_n = 1'b1;
        model_reset();
        ticks(2);
    endtask
    initial begin
        test_reset();
        test_single_fault();
        test_glitch();
        test_mask();
        test_simultaneous();
        test_clear();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
